// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared between DataMemory benches and the load/store unit.
//   SIZE_*      - access-size encodings on the DataMemory Size pins.
//   lsu_state_e - load/store unit controller state encodings.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/load_extend.sv
// load_extend: right-justified load data extension (combinational).
//   i_size   - access size (byte/half/word); other encodings pass data through.
//   i_signed - 1 = sign-extend byte/half, 0 = zero-extend.
//   i_din    - raw data from DataMemory DO; upper bits don't-care for byte/half.
//   o_dout   - extended result.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  // NOTE: assign a default before the case so every path drives o_dout and no latch is inferred.
  always_comb begin
    o_dout = i_din;
    case (i_size)
      SIZE_BYTE: o_dout = {{(DATA_W-8){i_signed & i_din[7]}}, i_din[7:0]};
      SIZE_HALF: o_dout = {{(DATA_W-16){i_signed & i_din[15]}}, i_din[15:0]};
      default:   o_dout = i_din;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage controller directly upstream of DataMemory.
// Accepts one load/store at a time, checks alignment, drives DataMemory for a
// single ACCESS cycle, and returns a tagged (data or fault) response.
//   clk, reset           - clock; synchronous active-high reset.
//   req_*                - request handshake (valid/ready) and request fields.
//   mem_A/DI/Size/RW/E   - DataMemory pins; mem_DO is its combinational read data.
//   rsp_*                - response handshake (valid/ready) with data, tag, fault.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_DI,
  input  logic [DATA_W-1:0] mem_DO,
  output logic [1:0]        mem_Size,
  output logic              mem_RW,
  output logic              mem_E,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_fault
);

  lsu_state_e        r_state;
  lsu_state_e        w_next_state;
  logic              r_load;
  logic              r_signed;
  logic [TAG_W-1:0]  r_tag;
  logic              w_accept;
  logic              w_misaligned;
  logic              w_illegal;
  logic [DATA_W-1:0] w_ext_data;

  assign req_ready = (r_state == IDLE) && !reset;
  assign w_accept  = req_valid && req_ready;

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
  always_comb begin
    w_misaligned = 1'b0;
    case (req_size)
      SIZE_HALF: w_misaligned = req_addr[0];
      SIZE_WORD: w_misaligned = |req_addr[1:0];
      default:   w_misaligned = 1'b0;
    endcase
  end

  assign w_illegal = (req_size == SIZE_ILL) || w_misaligned;

  // mem_Size holds the registered request size throughout ACCESS, so it
  // doubles as the extension select.
  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .i_size   (mem_Size),
    .i_signed (r_signed),
    .i_din    (mem_DO),
    .o_dout   (w_ext_data)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_illegal ? RESP : ACCESS;
      ACCESS:  w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_A     <= '0;
      mem_DI    <= '0;
      mem_Size  <= SIZE_WORD;
      mem_RW    <= 1'b0;
      mem_E     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_fault <= 1'b0;
      r_load    <= 1'b0;
      r_signed  <= 1'b0;
      r_tag     <= '0;
    end else begin
      // Write strobes are single-cycle pulses; address/data/size hold their
      // last values outside ACCESS.
      mem_E  <= 1'b0;
      mem_RW <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              // Faults skip ACCESS entirely and never touch the memory pins.
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
              rsp_data  <= '0;
              rsp_tag   <= req_tag;
            end else begin
              mem_A    <= req_addr;
              mem_Size <= req_size;
              r_load   <= req_load;
              r_signed <= req_signed;
              r_tag    <= req_tag;
              if (!req_load) begin
                mem_DI <= req_wdata;
                mem_E  <= 1'b1;
                mem_RW <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_fault <= 1'b0;
          rsp_tag   <= r_tag;
          rsp_data  <= r_load ? w_ext_data : '0;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_tag;
  logic [7:0]  mem_A;
  logic [31:0] mem_DI;
  logic [31:0] mem_DO;
  logic [1:0]  mem_Size;
  logic        mem_RW;
  logic        mem_E;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        rsp_fault;

  int n_tests = 0;
  int n_fail  = 0;
  int e_count = 0;

  load_store_unit #(
    .ADDR_W (8),
    .DATA_W (32),
    .TAG_W  (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_tag    (req_tag),
    .mem_A      (mem_A),
    .mem_DI     (mem_DI),
    .mem_DO     (mem_DO),
    .mem_Size   (mem_Size),
    .mem_RW     (mem_RW),
    .mem_E      (mem_E),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_fault  (rsp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte-addressed DataMemory model with combinational read.
  logic [7:0] mem [0:255];

  always @(posedge clk) begin
    if (reset && !mem_E) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_E && mem_RW) begin
      mem[mem_A] <= mem_DI[7:0];
      if (mem_Size != 2'b00) mem[mem_A + 8'd1] <= mem_DI[15:8];
      if (mem_Size == 2'b10) begin
        mem[mem_A + 8'd2] <= mem_DI[23:16];
        mem[mem_A + 8'd3] <= mem_DI[31:24];
      end
    end
  end

  assign mem_DO = {mem[mem_A + 8'd3], mem[mem_A + 8'd2], mem[mem_A + 8'd1], mem[mem_A]};

  // Counts cycles in which the write enable was high at a rising edge.
  always @(posedge clk) begin
    if (mem_E) e_count <= e_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One complete transaction with rsp_ready asserted in the first RESP cycle.
  task automatic run_req(input string name, input logic ld, input logic [1:0] sz,
                         input logic sg, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [4:0] tag, input logic exp_fault,
                         input logic [31:0] exp_data);
    int         e0;
    logic [7:0] prev_a;
    @(negedge clk);
    e0     = e_count;
    prev_a = mem_A;
    check({name, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_load   = ld;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_tag    = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!exp_fault) begin
      check({name, "_acc_E"}, 32'(mem_E), 32'(!ld));
      check({name, "_acc_RW"}, 32'(mem_RW), 32'(!ld));
      check({name, "_acc_A"}, 32'(mem_A), 32'(addr));
      check({name, "_acc_Size"}, 32'(mem_Size), 32'(sz));
      if (!ld) check({name, "_acc_DI"}, mem_DI, wd);
      check({name, "_acc_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({name, "_acc_req_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end else begin
      check({name, "_flt_A_held"}, 32'(mem_A), 32'(prev_a));
      check({name, "_flt_RW"}, 32'(mem_RW), 32'd0);
    end
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({name, "_rsp_E"}, 32'(mem_E), 32'd0);
    check({name, "_rsp_fault"}, 32'(rsp_fault), 32'(exp_fault));
    check({name, "_rsp_data"}, rsp_data, exp_data);
    check({name, "_rsp_tag"}, 32'(rsp_tag), 32'(tag));
    check({name, "_rsp_req_ready"}, 32'(req_ready), 32'd0);
    check({name, "_E_cycles"}, 32'(e_count - e0), 32'((!ld && !exp_fault) ? 1 : 0));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({name, "_hs_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_hs_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_load   = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 32'h0;
    req_tag    = 5'd0;
    rsp_ready  = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mem_E", 32'(mem_E), 32'd0);
    check("rst_mem_RW", 32'(mem_RW), 32'd0);
    check("rst_mem_A", 32'(mem_A), 32'd0);
    check("rst_mem_DI", mem_DI, 32'd0);
    check("rst_mem_Size", 32'(mem_Size), 32'd2);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release_req_ready", 32'(req_ready), 32'd1);

    // Word store then word load.
    run_req("st_w0c", 1'b0, 2'b10, 1'b0, 8'h0C, 32'h33445566, 5'd3, 1'b0, 32'h0);
    run_req("ld_w0c", 1'b1, 2'b10, 1'b0, 8'h0C, 32'h0, 5'd7, 1'b0, 32'h33445566);

    // Byte store, signed and unsigned byte loads.
    run_req("st_b00", 1'b0, 2'b00, 1'b0, 8'h00, 32'h000000A6, 5'd1, 1'b0, 32'h0);
    run_req("ld_b00_s", 1'b1, 2'b00, 1'b1, 8'h00, 32'h0, 5'd2, 1'b0, 32'hFFFFFFA6);
    run_req("ld_b00_u", 1'b1, 2'b00, 1'b0, 8'h00, 32'h0, 5'd31, 1'b0, 32'h000000A6);

    // Halfword store, half loads, byte 0x05 is the upper half byte (little-endian).
    run_req("st_h04", 1'b0, 2'b01, 1'b0, 8'h04, 32'h0000ABCD, 5'd5, 1'b0, 32'h0);
    run_req("ld_h04_s", 1'b1, 2'b01, 1'b1, 8'h04, 32'h0, 5'd6, 1'b0, 32'hFFFFABCD);
    run_req("ld_h04_u", 1'b1, 2'b01, 1'b0, 8'h04, 32'h0, 5'd8, 1'b0, 32'h0000ABCD);
    run_req("ld_b05_s", 1'b1, 2'b00, 1'b1, 8'h05, 32'h0, 5'd11, 1'b0, 32'hFFFFFFAB);
    run_req("ld_b0f_s", 1'b1, 2'b00, 1'b1, 8'h0F, 32'h0, 5'd12, 1'b0, 32'h00000033);
    run_req("ld_w04_s", 1'b1, 2'b10, 1'b1, 8'h04, 32'h0, 5'd13, 1'b0, 32'h0000ABCD);

    // Faults, including a faulting store.
    run_req("flt_w06", 1'b1, 2'b10, 1'b0, 8'h06, 32'h0, 5'd14, 1'b1, 32'h0);
    run_req("flt_h03", 1'b1, 2'b01, 1'b1, 8'h03, 32'h0, 5'd15, 1'b1, 32'h0);
    run_req("flt_sz11", 1'b1, 2'b11, 1'b0, 8'h00, 32'h0, 5'd16, 1'b1, 32'h0);
    run_req("flt_st_w02", 1'b0, 2'b10, 1'b0, 8'h02, 32'h12345678, 5'd17, 1'b1, 32'h0);
    run_req("ld_w0c_after_flt", 1'b1, 2'b10, 1'b0, 8'h0C, 32'h0, 5'd18, 1'b0, 32'h33445566);

    // Backpressure: response held while a second request waits.
    @(negedge clk);
    req_valid  = 1'b1;
    req_load   = 1'b1;
    req_size   = 2'b01;
    req_signed = 1'b0;
    req_addr   = 8'h04;
    req_tag    = 5'd9;
    @(posedge clk);
    #1;
    req_size = 2'b00;
    req_addr = 8'h05;
    req_tag  = 5'd10;
    check("bp_acc_A", 32'(mem_A), 32'h04);
    @(posedge clk);
    #1;
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rsp_data", rsp_data, 32'h0000ABCD);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_hold%0d_data", i), rsp_data, 32'h0000ABCD);
      check($sformatf("bp_hold%0d_tag", i), 32'(rsp_tag), 32'd9);
      check($sformatf("bp_hold%0d_fault", i), 32'(rsp_fault), 32'd0);
      check($sformatf("bp_hold%0d_req_ready", i), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp_hs_req_ready", 32'(req_ready), 32'd1);
    check("bp_hs_not_accepted_A", 32'(mem_A), 32'h04);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp_second_A", 32'(mem_A), 32'h05);
    check("bp_second_Size", 32'(mem_Size), 32'd0);
    check("bp_second_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("bp_second_valid", 32'(rsp_valid), 32'd1);
    check("bp_second_data", rsp_data, 32'h000000AB);
    check("bp_second_tag", 32'(rsp_tag), 32'd10);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_second_hs_valid", 32'(rsp_valid), 32'd0);

    // Reset during the ACCESS cycle of a store drops the transaction.
    @(negedge clk);
    req_valid = 1'b1;
    req_load  = 1'b0;
    req_size  = 2'b10;
    req_addr  = 8'h10;
    req_wdata = 32'hDEADBEEF;
    req_tag   = 5'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rsta_acc_E", 32'(mem_E), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rsta_E", 32'(mem_E), 32'd0);
    check("rsta_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rsta_req_ready_in_reset", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rsta_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rsta_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
    end

    // Unit is usable again after the aborted store.
    run_req("post_rst_st", 1'b0, 2'b10, 1'b0, 8'h20, 32'h80000001, 5'd20, 1'b0, 32'h0);
    run_req("post_rst_ld", 1'b1, 2'b01, 1'b1, 8'h22, 32'h0, 5'd21, 1'b0, 32'hFFFF8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
